// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with a 2-flop input synchroniser,
// majority-vote mid-bit sampling, false-start rejection and parity/framing flags.
// Define UART_RX_FIFO_EN to add a show-ahead receive FIFO (adds rx_rd/overrun).
module uart_rx_param #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 parity_err,
    output logic                 frame_err
`ifdef UART_RX_FIFO_EN
    ,
    input  logic                 rx_rd,
    output logic                 overrun
`endif
);

    localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned S_W   = $clog2(OVERSAMPLE);
    localparam int unsigned M     = OVERSAMPLE / 2;
    localparam int unsigned B_W   = $clog2(DATA_BITS);

    // Reject configurations the receiver cannot time correctly
    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_rx_param: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 2");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("uart_rx_param: FIFO_DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_t;

    state_t               state;
    logic                 rx_s1;
    logic                 rx_s2;
    logic                 rx_q;
    logic [DIV_W-1:0]     div_cnt;
    logic [S_W-1:0]       s_cnt;
    logic                 v_a;
    logic                 v_b;
    logic [DATA_BITS-1:0] shreg;
    logic [B_W-1:0]       bit_cnt;
    logic                 stop_cnt;
    logic                 par_bad;
    logic                 stop_bad;

    logic tick;
    logic mid_tick;
    logic end_tick;
    logic vote;
    logic fall;
    logic exp_par;

    // Synchronise rx; rx_q holds the previous synchronised value for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_q  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_q  <= rx_s2;
        end
    end

    assign fall     = rx_q & ~rx_s2;
    assign tick     = (state != S_IDLE) && (div_cnt == DIV_W'(DIV - 1));
    assign mid_tick = tick && (s_cnt == S_W'(M + 1));
    assign end_tick = tick && (s_cnt == S_W'(OVERSAMPLE - 1));
    assign vote     = (v_a & v_b) | (v_a & rx_s2) | (v_b & rx_s2);
    assign exp_par  = (PARITY == 1) ? ~^shreg : ^shreg;
    assign rx_busy  = (state != S_IDLE);

    // Oversample tick divider, held at zero in IDLE so sampling aligns to the start edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if ((state == S_IDLE) || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Frame FSM with sample counter, vote capture, data shift and error latching
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            s_cnt    <= '0;
            v_a      <= 1'b0;
            v_b      <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                s_cnt <= '0;
            end else if (tick) begin
                s_cnt <= end_tick ? '0 : s_cnt + S_W'(1);
            end
            if (tick && (s_cnt == S_W'(M - 1))) begin
                v_a <= rx_s2;
            end
            if (tick && (s_cnt == S_W'(M))) begin
                v_b <= rx_s2;
            end

            case (state)
                S_IDLE: begin
                    if (fall) begin
                        state    <= S_START;
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        par_bad  <= 1'b0;
                        stop_bad <= 1'b0;
                    end
                end
                S_START: begin
                    if (mid_tick && vote) begin
                        state <= S_IDLE;
                    end else if (end_tick) begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (mid_tick) begin
                        shreg <= {vote, shreg[DATA_BITS-1:1]};
                    end
                    if (end_tick) begin
                        if (bit_cnt == B_W'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= (PARITY == 0) ? S_STOP : S_PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + B_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (mid_tick) begin
                        par_bad <= vote ^ exp_par;
                    end
                    if (end_tick) begin
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    // Leave at the final stop bit's mid-point so a following start edge is seen
                    if (mid_tick) begin
                        if (!vote) begin
                            stop_bad <= 1'b1;
                        end
                        if (stop_cnt == 1'(STOP_BITS - 1)) begin
                            state <= S_DONE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef UART_RX_FIFO_EN
    localparam int unsigned P_W = $clog2(FIFO_DEPTH);
    localparam int unsigned C_W = P_W + 1;
    localparam int unsigned E_W = DATA_BITS + 2;

    logic [E_W-1:0] mem [FIFO_DEPTH];
    logic [P_W-1:0] wr_ptr;
    logic [P_W-1:0] rd_ptr;
    logic [C_W-1:0] count;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;
    logic           do_push;
    logic [E_W-1:0] head;

    assign push    = (state == S_DONE);
    assign full    = (count == C_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign pop     = rx_rd && !empty;
    assign do_push = push && (!full || pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    assign rx_data    = head[DATA_BITS-1:0];
    assign parity_err = head[DATA_BITS];
    assign frame_err  = head[DATA_BITS+1];
    assign rx_valid   = !empty;

    // FIFO storage; entries are only visible once counted, so no reset is needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= {stop_bad, par_bad, shreg};
        end
    end

    // FIFO pointers, occupancy and overrun pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push && full && !pop;
            if (do_push) begin
                wr_ptr <= wr_ptr + P_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + P_W'(1);
            end
            if (do_push && !pop) begin
                count <= count + C_W'(1);
            end else if (!do_push && pop) begin
                count <= count - C_W'(1);
            end
        end
    end
`else
    // Deliver the completed frame and pulse rx_valid for one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid <= (state == S_DONE);
            if (state == S_DONE) begin
                rx_data    <= shreg;
                parity_err <= par_bad;
                frame_err  <= stop_bad;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed bench for uart_rx_param (8N1 and 8E1 instances,
// scaled clock so one bit is 64 cycles). Honours UART_RX_FIFO_EN.
module tb_uart_rx_param;

    localparam int unsigned CLK_FREQ = 614_400;
    localparam int unsigned BAUD     = 9600;
    localparam int unsigned OS       = 16;
    localparam int          BIT      = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic [7:0] data0;
    logic [7:0] data1;
    logic       valid0, valid1, busy0, busy1, perr0, perr1, ferr0, ferr1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

`ifdef UART_RX_FIFO_EN
    logic rd0 = 1'b0;
    logic rd1 = 1'b0;
    logic ovr0, ovr1;
    int   ovr_cnt0 = 0;
`else
    int vcnt0 = 0;
    int vcnt1 = 0;
    int busy_seen0 = 0;
`endif

    uart_rx_param #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .rx_data(data0), .rx_valid(valid0),
        .rx_busy(busy0), .parity_err(perr0), .frame_err(ferr0)
`ifdef UART_RX_FIFO_EN
        , .rx_rd(rd0), .overrun(ovr0)
`endif
    );

    uart_rx_param #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .rx_data(data1), .rx_valid(valid1),
        .rx_busy(busy1), .parity_err(perr1), .frame_err(ferr1)
`ifdef UART_RX_FIFO_EN
        , .rx_rd(rd1), .overrun(ovr1)
`endif
    );

    // Count output events away from the active edge
    always @(negedge clk) begin
`ifdef UART_RX_FIFO_EN
        if (ovr0) ovr_cnt0++;
`else
        if (valid0) vcnt0++;
        if (valid1) vcnt1++;
        if (busy0) busy_seen0++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 0) rx0 = v;
        else rx1 = v;
    endtask

    task automatic drive_bit(input int which, input logic v);
        set_line(which, v);
        hold(BIT);
    endtask

    // par < 0: no parity bit; otherwise par[0] is sent as the parity bit
    task automatic send(input int which, input logic [7:0] d, input int par, input logic stop);
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
        if (par >= 0) drive_bit(which, par[0]);
        drive_bit(which, stop);
        set_line(which, 1'b1);
        hold(2 * BIT);
    endtask

`ifdef UART_RX_FIFO_EN
    logic [7:0] exp_q [4] = '{8'h57, 8'h53, 8'hF3, 8'h01};

    initial begin
        hold(10);
        @(negedge clk);
        check("rst_valid", 32'(valid0), 32'h0);
        check("rst_data", 32'(data0), 32'h0);
        check("rst_ovr", 32'(ovr0), 32'h0);
        rst = 1'b1;
        hold(BIT);
        send(0, 8'h57, -1, 1'b1);
        send(0, 8'h53, -1, 1'b1);
        send(0, 8'hF3, -1, 1'b1);
        send(0, 8'h01, -1, 1'b1);
        @(negedge clk);
        check("fill_ovr", 32'(ovr_cnt0), 32'd0);
        check("fill_valid", 32'(valid0), 32'h1);
        check("fill_head", 32'(data0), 32'h57);
        send(0, 8'h02, -1, 1'b1);
        @(negedge clk);
        check("ovr_pulse", 32'(ovr_cnt0), 32'd1);
        check("ovr_head", 32'(data0), 32'h57);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("pop_data", 32'(data0), 32'(exp_q[i]));
            check("pop_valid", 32'(valid0), 32'h1);
            check("pop_ferr", 32'(ferr0), 32'h0);
            @(posedge clk);
            #1 rd0 = 1'b1;
            @(posedge clk);
            #1 rd0 = 1'b0;
        end
        @(negedge clk);
        check("empty_valid", 32'(valid0), 32'h0);
        check("empty_ovr", 32'(ovr_cnt0), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
`else
    initial begin
        logic [7:0] d;
        int b;
        hold(10);
        @(negedge clk);
        check("rst_data", 32'(data0), 32'h0);
        check("rst_valid", 32'(valid0), 32'h0);
        check("rst_busy", 32'(busy0), 32'h0);
        check("rst_perr", 32'(perr0), 32'h0);
        check("rst_ferr", 32'(ferr0), 32'h0);
        rst = 1'b1;
        hold(BIT);

        // Clean 8N1 frame
        send(0, 8'h57, -1, 1'b1);
        check("f57_count", 32'(vcnt0), 32'd1);
        check("f57_data", 32'(data0), 32'h57);
        check("f57_perr", 32'(perr0), 32'h0);
        check("f57_ferr", 32'(ferr0), 32'h0);
        check("f57_busy", 32'(busy0), 32'h0);

        // Short low glitch is rejected as a false start
        b = busy_seen0;
        set_line(0, 1'b0);
        hold(10);
        set_line(0, 1'b1);
        hold(2 * BIT);
        check("glitch_count", 32'(vcnt0), 32'd1);
        check("glitch_busy_seen", 32'(busy_seen0 != b), 32'h1);
        check("glitch_busy", 32'(busy0), 32'h0);
        check("glitch_data", 32'(data0), 32'h57);

        // Stop bit forced low, then recovery
        send(0, 8'h53, -1, 1'b0);
        check("f53_count", 32'(vcnt0), 32'd2);
        check("f53_data", 32'(data0), 32'h53);
        check("f53_ferr", 32'(ferr0), 32'h1);
        send(0, 8'h57, -1, 1'b1);
        check("rec_count", 32'(vcnt0), 32'd3);
        check("rec_data", 32'(data0), 32'h57);
        check("rec_ferr", 32'(ferr0), 32'h0);

        // Break: whole frame low delivers once, no retrigger while low
        set_line(0, 1'b0);
        hold(12 * BIT);
        set_line(0, 1'b1);
        hold(2 * BIT);
        check("brk_count", 32'(vcnt0), 32'd4);
        check("brk_data", 32'(data0), 32'h0);
        check("brk_ferr", 32'(ferr0), 32'h1);
        check("brk_busy", 32'(busy0), 32'h0);
        send(0, 8'h57, -1, 1'b1);
        check("post_brk_count", 32'(vcnt0), 32'd5);
        check("post_brk_ferr", 32'(ferr0), 32'h0);

        // Even parity: 0x53 has four ones (parity bit 0), 0x57 has five (parity bit 1)
        send(1, 8'h53, 1, 1'b1);
        check("par_bad_count", 32'(vcnt1), 32'd1);
        check("par_bad_data", 32'(data1), 32'h53);
        check("par_bad_perr", 32'(perr1), 32'h1);
        check("par_bad_ferr", 32'(ferr1), 32'h0);
        send(1, 8'h53, 0, 1'b1);
        check("par_ok_count", 32'(vcnt1), 32'd2);
        check("par_ok_perr", 32'(perr1), 32'h0);
        send(1, 8'h57, 1, 1'b1);
        check("par57_data", 32'(data1), 32'h57);
        check("par57_perr", 32'(perr1), 32'h0);

        // Reset during data bit 4 discards the frame
        d = 8'hF3;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, d[i]);
        set_line(0, d[4]);
        hold(BIT / 2);
        rst = 1'b0;
        hold(4);
        @(negedge clk);
        check("mid_rst_data", 32'(data0), 32'h0);
        check("mid_rst_busy", 32'(busy0), 32'h0);
        check("mid_rst_valid", 32'(valid0), 32'h0);
        set_line(0, 1'b1);
        hold(4);
        rst = 1'b1;
        hold(2 * BIT);
        check("mid_rst_count", 32'(vcnt0), 32'd5);
        send(0, 8'hF3, -1, 1'b1);
        check("fF3_count", 32'(vcnt0), 32'd6);
        check("fF3_data", 32'(data0), 32'hF3);
        check("fF3_perr", 32'(perr0), 32'h0);
        check("fF3_ferr", 32'(ferr0), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
`endif

endmodule
